// File: rtl/pwm_generator.sv
// PWM generator: prescaled period counter compared against a per-period latched duty value.
// Duty and prescaler select reload only at period boundaries, so each period is glitch-free.
module pwm_generator #(
  parameter int WORD_LENGTH = 8,
  parameter int FREQ_LENGTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] dutyCycle,
  input  logic [FREQ_LENGTH-1:0] frequency,
  output logic                   pwm_output
);

  // Prescaler must reach 2^(2^FREQ_LENGTH - 1) - 1 for the largest select code.
  localparam int PRE_W = (1 << FREQ_LENGTH) - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [PRE_W-1:0]       pre;
  logic [WORD_LENGTH-1:0] cnt;
  logic [WORD_LENGTH-1:0] duty_q;
  logic [FREQ_LENGTH-1:0] freq_q;
  logic                   tick;

  // Terminal prescaler value D-1 = 2^f - 1, i.e. the low f bits set.
  function automatic logic [PRE_W-1:0] pre_terminal(input logic [FREQ_LENGTH-1:0] f);
    logic [PRE_W-1:0] t;
    for (int i = 0; i < PRE_W; i++) begin
      t[i] = (i < int'(f));
    end
    return t;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = RUN;
      RUN:     if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tick = (state == RUN) && (pre == pre_terminal(freq_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre    <= '0;
      cnt    <= '0;
      duty_q <= '0;
      freq_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pre    <= '0;
            cnt    <= '0;
            duty_q <= dutyCycle;
            freq_q <= frequency;
          end
        end
        RUN: begin
          if (!start) begin
            pre <= '0;
            cnt <= '0;
          end else if (tick) begin
            pre <= '0;
            cnt <= cnt + 1'b1;
            // Counter wraps to 0 on this tick: next period takes fresh settings.
            if (cnt == {WORD_LENGTH{1'b1}}) begin
              duty_q <= dutyCycle;
              freq_q <= frequency;
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end
        default: begin
          pre <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  assign pwm_output = (state == RUN) && (cnt < duty_q);

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed scenarios plus random traffic, checked each cycle
// against an elapsed-time model of the waveform.
module tb_pwm_generator;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dutyCycle = 8'd0;
  logic [1:0] frequency = 2'd0;
  logic       pwm_output;

  int total = 0;
  int bad = 0;
  int hi_cnt = 0;

  // Model: clocks elapsed in the current period, with the period's duty and divide ratio.
  bit m_run = 1'b0;
  int m_el = 0;
  int m_duty = 0;
  int m_d = 1;

  always #5 clk = ~clk;

  pwm_generator #(.WORD_LENGTH(8), .FREQ_LENGTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dutyCycle  (dutyCycle),
    .frequency  (frequency),
    .pwm_output (pwm_output)
  );

  function automatic logic model_out();
    return m_run && ((m_el / m_d) < m_duty);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_run  = 1'b1;
        m_el   = 0;
        m_duty = int'(dutyCycle);
        m_d    = 1 << frequency;
      end
    end else if (!start) begin
      m_run = 1'b0;
    end else begin
      m_el++;
      if (m_el == (1 << W) * m_d) begin
        m_el   = 0;
        m_duty = int'(dutyCycle);
        m_d    = 1 << frequency;
      end
    end
    #1;
    chk(tag, {31'd0, pwm_output}, {31'd0, model_out()});
    if (pwm_output === 1'b1) hi_cnt++;
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    // Reset held: inputs ignored, output low.
    reset = 1'b0;
    start = 1'b1;
    dutyCycle = 8'h80;
    frequency = 2'd0;
    #1;
    chk("reset_init", {31'd0, pwm_output}, 32'd0);
    run_n(5, "reset_hold");

    // Basic run: duty 8, D=2.
    reset = 1'b1;
    dutyCycle = 8'd8;
    frequency = 2'd1;
    hi_cnt = 0;
    step("basic_enter");
    chk("basic_first_rise", {31'd0, pwm_output}, 32'd1);
    run_n(511, "basic");
    chk("basic_high_clocks", hi_cnt, 32'd16);
    step("basic_wrap");
    chk("basic_period_rise", {31'd0, pwm_output}, 32'd1);
    start = 1'b0;
    step("basic_stop");

    // Frequency codes 0/2/3 with duty 64.
    for (int k = 0; k < 3; k++) begin
      int f;
      f = (k == 0) ? 0 : k + 1;
      dutyCycle = 8'd64;
      frequency = f[1:0];
      start = 1'b1;
      hi_cnt = 0;
      run_n(256 << f, "freq_run");
      chk("freq_high_clocks", hi_cnt, 64 << f);
      step("freq_next_period");
      chk("freq_period_rise", {31'd0, pwm_output}, 32'd1);
      start = 1'b0;
      step("freq_stop");
    end

    // Extreme duty values.
    dutyCycle = 8'd0;
    frequency = 2'd0;
    start = 1'b1;
    hi_cnt = 0;
    run_n(512, "duty_zero");
    chk("duty_zero_high", hi_cnt, 32'd0);
    start = 1'b0;
    step("duty_zero_stop");
    dutyCycle = 8'd255;
    start = 1'b1;
    hi_cnt = 0;
    run_n(256, "duty_max");
    chk("duty_max_high", hi_cnt, 32'd255);
    chk("duty_max_last_low", {31'd0, pwm_output}, 32'd0);
    start = 1'b0;
    step("duty_max_stop");

    // Mid-period duty change only takes effect next period.
    dutyCycle = 8'd8;
    start = 1'b1;
    hi_cnt = 0;
    run_n(4, "mid_early");
    dutyCycle = 8'd100;
    run_n(252, "mid_cur");
    chk("mid_cur_high", hi_cnt, 32'd8);
    hi_cnt = 0;
    run_n(256, "mid_next");
    chk("mid_next_high", hi_cnt, 32'd100);
    start = 1'b0;
    step("mid_stop");

    // Abort with start, then restart.
    start = 1'b1;
    run_n(20, "abort_run");
    start = 1'b0;
    step("abort_edge");
    chk("abort_low", {31'd0, pwm_output}, 32'd0);
    start = 1'b1;
    hi_cnt = 0;
    step("restart_edge");
    chk("restart_high", {31'd0, pwm_output}, 32'd1);
    run_n(255, "restart_run");
    chk("restart_high_clocks", hi_cnt, 32'd100);

    // Abort with asynchronous reset mid-pulse.
    run_n(10, "areset_run");
    chk("areset_pre_high", {31'd0, pwm_output}, 32'd1);
    #2;
    reset = 1'b0;
    m_run = 1'b0;
    #1;
    chk("areset_async_low", {31'd0, pwm_output}, 32'd0);
    run_n(3, "areset_hold");
    reset = 1'b1;
    step("areset_release");
    chk("areset_rerun_high", {31'd0, pwm_output}, 32'd1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) dutyCycle = 8'($urandom);
      if ($urandom_range(0, 63) == 0) frequency = 2'($urandom);
      if ($urandom_range(0, 299) == 0) start = ~start;
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        m_run = 1'b0;
        #1;
        chk("rand_async_low", {31'd0, pwm_output}, 32'd0);
        step("rand_reset");
        reset = 1'b1;
      end else begin
        step("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter WORD_LENGTH, default 8, SHALL set the width of dutyCycle and of the period counter.
REQ-002 Parameter FREQ_LENGTH, default 2, SHALL set the width of frequency (the prescaler select).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 start  input  1  SHALL be the level-sensitive run enable (1 = generate PWM, 0 = stop).
REQ-006 dutyCycle  input  WORD_LENGTH  SHALL be the high-time in counter steps per period.
REQ-007 frequency  input  FREQ_LENGTH  SHALL be the prescaler select; divide ratio D = 2^frequency clocks per counter step.
REQ-008 pwm_output  output  1  SHALL be the PWM waveform.

Function
REQ-009 The block SHALL have two states, IDLE and RUN.
REQ-010 IDLE with start=1 at a clock edge SHALL go to RUN and clear prescaler and counter to 0 on that edge.
  - Same edge: latch dutyCycle into duty_q and frequency into freq_q.
REQ-011 RUN with start=0 at a clock edge SHALL go to IDLE and clear prescaler and counter to 0 on that edge.
REQ-012 IDLE with start=0, and RUN with start=1, SHALL hold the current state.
REQ-013 In RUN, the prescaler SHALL count 0..D-1, with D = 2^freq_q.
  - At D-1 it wraps to 0 and issues a one-clock tick.
  - With freq_q=0 (D=1), a tick occurs every clock.
REQ-014 Each tick SHALL increment the WORD_LENGTH-bit period counter.
  - Wraps modulo 2^WORD_LENGTH (255 -> 0 by default).
  - Period = 2^WORD_LENGTH * D clocks.
REQ-015 On the tick that wraps the counter to 0, duty_q and freq_q SHALL reload from dutyCycle and frequency.
  - Input changes mid-period never affect the current period.
REQ-016 pwm_output SHALL equal (state==RUN) AND (counter < duty_q), unsigned compare.
  - Decoded only from registered state; no direct input-to-output path.
  - High time per period = duty_q * D clocks.
REQ-017 duty_q=0 SHALL give constant low; duty_q=2^WORD_LENGTH-1 SHALL give high for all but the last counter step (100% is not representable).
REQ-018 In IDLE, pwm_output SHALL be 0.
REQ-019 The first high sample in RUN (duty_q>0) SHALL appear in the clock cycle immediately after the edge that entered RUN.
REQ-020 Latency:
  - start deassertion drives pwm_output low at the next edge.
  - start reassertion restarts a fresh period from counter 0 with newly latched inputs.

Reset
REQ-021 reset=0 SHALL, without waiting for clk:
  - force state to IDLE;
  - clear prescaler, counter, duty_q and freq_q to 0;
  - force pwm_output to 0.
REQ-022 While reset=0, all other inputs SHALL be ignored.
REQ-023 After reset releases, start=1 SHALL be honoured at the first rising edge at which reset=1 is sampled.
REQ-024 Reset asserted mid-period SHALL abort the period immediately; no partial pulse completes.

Verification
REQ-025 Scenario, reset: reset=0, start=1, dutyCycle=8'h80 -> pwm_output stays 0 and state stays IDLE throughout.
REQ-026 Scenario, basic run: reset released, then start=1, dutyCycle=8, frequency=1 (D=2) ->
  - high 16 clocks, low 496 clocks, period 512 clocks;
  - first rise one cycle after the start-sampling edge.
REQ-027 Scenario, frequency codes: dutyCycle=64, frequency=0/2/3 ->
  - high 64/256/512 clocks;
  - periods 256/1024/2048 clocks.
REQ-028 Scenario, extreme duty:
  - dutyCycle=0 -> output never rises;
  - dutyCycle=255 with frequency=0 -> high 255 clocks, low 1 clock per period.
REQ-029 Scenario, mid-period change: dutyCycle changes 8->100 mid-period -> current period keeps 8 steps high; next period has 100 steps high.
REQ-030 Scenario, abort and restart: start=0 mid-high-pulse -> output low at the next edge; start=1 again -> fresh period from counter 0. Repeating the same case with reset=0 instead of start=0 -> output low asynchronously.
